// File: rtl/multdiv_seq_ctrl.sv
// rtl/multdiv_seq_ctrl.sv - sequences the multi-cycle mul/div unit: operand latch, start pulse, pipeline stall, result hand-off
module multdiv_seq_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        isMul_dx,
  input  logic        isDiv_dx,
  input  logic        flush,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic        md_resultRDY,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        stall,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] result,
  output logic        exception
);

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_div_q, op_div_d;
  logic [31:0]      opa_q, opa_d;
  logic [31:0]      opb_q, opb_d;
  logic [31:0]      result_q, result_d;
  logic             exc_q, exc_d;
  logic             req;

  assign req = (isMul_dx | isDiv_dx) & ~flush;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_div_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_div_q <= op_div_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_div_d = op_div_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    exc_d    = exc_q;
    case (state_q)
      // md_resultRDY is deliberately not looked at here: stale results from an aborted op are dropped.
      IDLE: begin
        if (req) begin
          state_d  = START;
          opa_d    = operandA;
          opb_d    = operandB;
          op_div_d = ~isMul_dx;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = flush ? IDLE : BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else if (md_resultRDY) begin
          state_d  = DONE;
          result_d = md_result;
          exc_d    = md_exception;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          result_d = '0;
          exc_d    = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall        = 1'b0;
    busy         = 1'b0;
    md_ctrl_MULT = 1'b0;
    md_ctrl_DIV  = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      IDLE:  stall = req;
      START: begin
        stall        = 1'b1;
        busy         = 1'b1;
        md_ctrl_MULT = ~op_div_q;
        md_ctrl_DIV  = op_div_q;
      end
      BUSY: begin
        stall = 1'b1;
        busy  = 1'b1;
      end
      DONE: begin
        busy         = 1'b1;
        result_valid = 1'b1;
      end
      default: stall = 1'b0;
    endcase
    if (reset) begin
      stall        = 1'b0;
      md_ctrl_MULT = 1'b0;
      md_ctrl_DIV  = 1'b0;
      result_valid = 1'b0;
    end
  end

  assign md_operandA = opa_q;
  assign md_operandB = opb_q;
  assign result      = result_q;
  assign exception   = exc_q;

endmodule
